// File: rtl/useq_fifo_arb.sv
// Round-robin arbiter that funnels NREQ host requesters onto one useq mailbox FIFO port.
// Latency: push strobe 1 cycle after the decision cycle; pop response 3 cycles after it.
// Backpressure: req_ready is a one-cycle grant; pushes wait while the shadow level is full.
module useq_fifo_arb #(
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_write,
    input  logic [8*NREQ-1:0]             req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic                          rsp_valid,
    output logic [7:0]                    rsp_data,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic                          rsp_err,
    output logic                          read_fifo,
    output logic                          write_fifo,
    output logic [7:0]                    fifo_in,
    input  logic [7:0]                    fifo_out,
    input  logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH)-1:0] level,
    output logic                          busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int LW  = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_MAX  = LW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    GAP_LOAD = (MIN_GAP == 0) ? 4'd0 : 4'(MIN_GAP - 1);

    typedef enum logic [1:0] {IDLE, STROBE, RDCAP, GAP} state_t;

    // With no gap requested, a finished transaction returns straight to IDLE.
    localparam state_t AFTER_XFER = (MIN_GAP == 0) ? IDLE : GAP;

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [IDW-1:0]  win, win_nxt;
    logic            dir_wr, dir_wr_nxt;
    logic [3:0]      gap_cnt, gap_cnt_nxt;
    logic [LW-1:0]   level_nxt;
    logic [NREQ-1:0] req_ready_nxt;
    logic            rsp_valid_nxt, rsp_err_nxt, read_fifo_nxt, write_fifo_nxt, busy_nxt;
    logic [7:0]      rsp_data_nxt, fifo_in_nxt;
    logic [IDW-1:0]  rsp_id_nxt;

    logic [LW-1:0]   eff_level;
    logic [NREQ-1:0] eligible;
    logic            found;
    logic [IDW-1:0]  pick;
    logic [IDW:0]    idx;

    // Eligibility and round-robin search starting just after the last winner.
    // An empty useq FIFO means the shadow level is stale, so decide on zero.
    always_comb begin
        eff_level = fifo_empty ? '0 : level;
        eligible  = req_valid & ~(req_write & {NREQ{eff_level == LVL_MAX}});
        found     = 1'b0;
        pick      = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!found && eligible[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        win_nxt        = win;
        dir_wr_nxt     = dir_wr;
        gap_cnt_nxt    = gap_cnt;
        level_nxt      = level;
        req_ready_nxt  = '0;
        read_fifo_nxt  = 1'b0;
        write_fifo_nxt = 1'b0;
        rsp_valid_nxt  = 1'b0;
        rsp_err_nxt    = 1'b0;
        rsp_data_nxt   = rsp_data;
        rsp_id_nxt     = rsp_id;
        fifo_in_nxt    = fifo_in;
        case (state)
            IDLE: begin
                if (fifo_empty) level_nxt = '0;
                if (found) begin
                    ptr_nxt       = pick;
                    win_nxt       = pick;
                    dir_wr_nxt    = req_write[pick];
                    fifo_in_nxt   = req_data[8*pick +: 8];
                    req_ready_nxt = NREQ'(1) << pick;
                    if (req_write[pick]) begin
                        write_fifo_nxt = 1'b1;
                        state_nxt      = STROBE;
                    end else if (eff_level != '0) begin
                        read_fifo_nxt = 1'b1;
                        state_nxt     = STROBE;
                    end else begin
                        // Pop on empty: answer with an error, never touch the useq.
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_data_nxt  = 8'h00;
                        rsp_id_nxt    = pick;
                        state_nxt     = AFTER_XFER;
                        gap_cnt_nxt   = GAP_LOAD;
                    end
                end
            end
            STROBE: begin
                if (dir_wr) begin
                    level_nxt   = (level == LVL_MAX) ? level : level + LW'(1);
                    state_nxt   = AFTER_XFER;
                    gap_cnt_nxt = GAP_LOAD;
                end else begin
                    level_nxt = (level == '0) ? level : level - LW'(1);
                    state_nxt = RDCAP;
                end
            end
            RDCAP: begin
                // fifo_out was advanced by the useq at the end of the strobe cycle.
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = fifo_out;
                rsp_id_nxt    = win;
                state_nxt     = AFTER_XFER;
                gap_cnt_nxt   = GAP_LOAD;
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_nxt = IDLE;
                else gap_cnt_nxt = gap_cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, shadow level and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            win        <= '0;
            dir_wr     <= 1'b0;
            gap_cnt    <= 4'd0;
            level      <= '0;
            req_ready  <= '0;
            read_fifo  <= 1'b0;
            write_fifo <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_id     <= '0;
            fifo_in    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            win        <= win_nxt;
            dir_wr     <= dir_wr_nxt;
            gap_cnt    <= gap_cnt_nxt;
            level      <= level_nxt;
            req_ready  <= req_ready_nxt;
            read_fifo  <= read_fifo_nxt;
            write_fifo <= write_fifo_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_err    <= rsp_err_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_id     <= rsp_id_nxt;
            fifo_in    <= fifo_in_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_useq_fifo_arb.sv
// Bench for useq_fifo_arb: timeline reference model plus a behavioural useq mailbox.
// Latency: expectations are scheduled per cycle from each arbitration decision.
// Backpressure: requesters hold valid until granted; a CPU model drains the mailbox.
module tb_useq_fifo_arb;

    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int NC    = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT signals
    logic [NREQ-1:0]   rv = '0, rw = '0;
    logic [8*NREQ-1:0] rdat = '0;
    logic [7:0]        fifo_out = 8'h00;
    logic              fifo_empty = 1'b1;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid, rsp_err, read_fifo, write_fifo, busy;
    logic [7:0]        rsp_data, fifo_in;
    logic [1:0]        rsp_id, level;

    useq_fifo_arb #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_write(rw), .req_data(rdat),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .read_fifo(read_fifo), .write_fifo(write_fifo), .fifo_in(fifo_in),
        .fifo_out(fifo_out), .fifo_empty(fifo_empty), .level(level), .busy(busy));

    // two extra instances with MIN_GAP 0 and 3: one requester pushing forever into an always-empty useq
    logic [NREQ-1:0]   g_rv = 4'b0001, g_rw = 4'b0001;
    logic [8*NREQ-1:0] g_dat = 32'h0000_005A;
    logic [7:0]        g_fout = 8'h00;
    logic              g_empty = 1'b1;
    logic [NREQ-1:0]   g0_rdy, g3_rdy;
    logic              g0_rv, g0_err, g0_rd, g0_wr, g0_busy, g3_rv, g3_err, g3_rd, g3_wr, g3_busy;
    logic [7:0]        g0_rdat, g0_fin, g3_rdat, g3_fin;
    logic [1:0]        g0_id, g0_lvl, g3_id, g3_lvl;

    useq_fifo_arb #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .MIN_GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .req_valid(g_rv), .req_write(g_rw), .req_data(g_dat),
        .req_ready(g0_rdy), .rsp_valid(g0_rv), .rsp_data(g0_rdat), .rsp_id(g0_id),
        .rsp_err(g0_err), .read_fifo(g0_rd), .write_fifo(g0_wr), .fifo_in(g0_fin),
        .fifo_out(g_fout), .fifo_empty(g_empty), .level(g0_lvl), .busy(g0_busy));

    useq_fifo_arb #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .MIN_GAP(3)) dut_g3 (
        .clk(clk), .rst(rst), .req_valid(g_rv), .req_write(g_rw), .req_data(g_dat),
        .req_ready(g3_rdy), .rsp_valid(g3_rv), .rsp_data(g3_rdat), .rsp_id(g3_id),
        .rsp_err(g3_err), .read_fifo(g3_rd), .write_fifo(g3_wr), .fifo_in(g3_fin),
        .fifo_out(g_fout), .fifo_empty(g_empty), .level(g3_lvl), .busy(g3_busy));

    int tests = 0, fails = 0;
    int cyc = 0;

    // reference model state
    int m_ptr, m_lvl, cur_lvl, next_free;
    bit pending_read;
    logic [NREQ-1:0] e_rdy [NC];
    bit              e_wr [NC], e_rd [NC], e_rsp [NC], e_err [NC];
    logic [7:0]      e_fin [NC], e_rdat [NC];
    int              e_id [NC], lvl_set [NC];
    int              grants [$], gcyc [$];

    // useq mailbox model and environment
    logic [7:0]      uq [$];
    logic            saw_rd, saw_wr;
    logic [7:0]      saw_fin;
    logic [NREQ-1:0] saw_rdy;
    bit rand_mode, hold_all;
    int drain_pct, wr_pct;
    int g0_last, g3_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rv = '0; rw = '0; rdat = '0;
        hold_all = 0; rand_mode = 0; drain_pct = 0; wr_pct = 50;
        uq.delete(); fifo_out = 8'h00; fifo_empty = 1'b1;
        m_ptr = NREQ - 1; m_lvl = 0; cur_lvl = 0; next_free = 0; pending_read = 0;
        grants.delete(); gcyc.delete();
        saw_rd = 0; saw_wr = 0; saw_fin = 0; saw_rdy = '0;
        g0_last = -1; g3_last = -1;
        for (int i = 0; i < NC; i++) begin
            e_rdy[i] = '0; e_wr[i] = 0; e_rd[i] = 0; e_rsp[i] = 0; e_err[i] = 0;
            e_fin[i] = 0; e_rdat[i] = 0; e_id[i] = 0; lvl_set[i] = -1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Compare every DUT output of cycle t with the schedule.
    task automatic compare(input int t);
        if (lvl_set[t] >= 0) cur_lvl = lvl_set[t];
        chk("req_ready", 32'(req_ready), 32'(e_rdy[t]));
        chk("write_fifo", 32'(write_fifo), 32'(e_wr[t]));
        chk("read_fifo", 32'(read_fifo), 32'(e_rd[t]));
        if (e_wr[t]) chk("fifo_in", 32'(fifo_in), 32'(e_fin[t]));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp[t]));
        if (e_rsp[t]) begin
            chk("rsp_err", 32'(rsp_err), 32'(e_err[t]));
            chk("rsp_id", 32'(rsp_id), e_id[t]);
            chk("rsp_data", 32'(rsp_data), 32'(e_rdat[t]));
        end
        chk("level", 32'(level), cur_lvl);
        chk("busy", 32'(busy), 32'(t < next_free));
        if (g0_wr) begin
            if (g0_last >= 0) chk("gap0_period", t - g0_last, 2);
            g0_last = t;
        end
        if (g3_wr) begin
            if (g3_last >= 0) chk("gap3_period", t - g3_last, 5);
            g3_last = t;
        end
    endtask

    // One arbitration decision at cycle t, written as a schedule of future outputs.
    task automatic decide(input int t);
        int lv, w;
        if (t < next_free) return;
        lv = fifo_empty ? 0 : m_lvl;
        if (fifo_empty) lvl_set[t+1] = 0;
        m_lvl = lv;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (w < 0 && rv[i] && (!rw[i] || lv != DEPTH - 1)) w = i;
        end
        if (w < 0) begin
            next_free = t + 1;
            return;
        end
        m_ptr = w;
        grants.push_back(w);
        gcyc.push_back(t);
        e_rdy[t+1] = NREQ'(1) << w;
        if (rw[w]) begin
            e_wr[t+1] = 1; e_fin[t+1] = rdat[8*w +: 8];
            m_lvl = (lv < DEPTH - 1) ? lv + 1 : lv;
            lvl_set[t+2] = m_lvl;
            next_free = t + 2 + GAP;
        end else if (lv > 0) begin
            e_rd[t+1] = 1;
            e_rsp[t+3] = 1; e_err[t+3] = 0; e_id[t+3] = w;
            m_lvl = lv - 1;
            lvl_set[t+2] = m_lvl;
            pending_read = 1;
            next_free = t + 3 + GAP;
        end else begin
            e_rsp[t+1] = 1; e_err[t+1] = 1; e_rdat[t+1] = 8'h00; e_id[t+1] = w;
            next_free = t + 1 + GAP;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rv[i] && saw_rdy[i] && !hold_all) rv[i] = 1'b0;
            else if (rand_mode) begin
                if (rv[i]) begin
                    if ($urandom_range(63) == 0) rv[i] = 1'b0;
                    else if ($urandom_range(7) == 0) rdat[8*i +: 8] = 8'($urandom);
                end else if ($urandom_range(3) == 0) begin
                    rv[i] = 1'b1;
                    rw[i] = ($urandom_range(99) < wr_pct);
                    rdat[8*i +: 8] = 8'($urandom);
                end
            end
        end
        if (hold_all) rdat = $urandom;
    endtask

    // Check cycle cyc at the falling edge, then step to the next cycle.
    task automatic tick();
        @(negedge clk);
        compare(cyc);
        if (e_rd[cyc]) e_rdat[cyc+2] = (uq.size() > 0) ? uq[0] : 8'h00;
        decide(cyc);
        saw_rd = read_fifo; saw_wr = write_fifo; saw_fin = fifo_in; saw_rdy = req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (saw_wr) uq.push_back(saw_fin);
        if (saw_rd) begin
            fifo_out = (uq.size() > 0) ? uq.pop_front() : 8'h00;
            pending_read = 0;
        end
        if (!pending_read && uq.size() > 0 && $urandom_range(99) < drain_pct) void'(uq.pop_front());
        fifo_empty = (uq.size() == 0);
        drive();
    endtask

    task automatic wait_grants(input int n, input int limit);
        for (int k = 0; k < limit && grants.size() < n; k++) tick();
        chk("grant_count", grants.size(), n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_strobes", 32'({read_fifo, write_fifo, rsp_valid}), 0);

        // single push of 0xA5 from requester 1
        rv = 4'b0010; rw = 4'b0010; rdat[15:8] = 8'hA5;
        tick();
        chk("a5_write", 32'(write_fifo), 1);
        chk("a5_fifo_in", 32'(fifo_in), 32'hA5);
        chk("a5_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("a5_level", 32'(level), 1);
        repeat (4) tick();

        // fill to capacity, blocked fourth push, pop from requester 2 unblocks it
        do_reset();
        rv = 4'b1011; rw = 4'b1011; rdat = 32'h33_00_22_11;
        wait_grants(3, 30);
        rv[0] = 1'b1; rw[0] = 1'b1; rdat[7:0] = 8'h44;
        repeat (10) tick();
        chk("full_blocked", grants.size(), 3);
        chk("full_level", 32'(level), 3);
        rv[2] = 1'b1; rw[2] = 1'b0;
        for (int k = 0; k < 20 && !rsp_valid; k++) tick();
        chk("pop_valid", 32'(rsp_valid), 1);
        chk("pop_data", 32'(rsp_data), 32'h11);
        chk("pop_id", 32'(rsp_id), 2);
        if (gcyc.size() == 4) chk("pop_latency", cyc - gcyc[3], 3);
        else chk("pop_grants", gcyc.size(), 4);
        wait_grants(5, 20);
        if (grants.size() == 5) chk("resume_winner", grants[4], 0);
        repeat (4) tick();

        // pop on empty from requester 3
        do_reset();
        rv = 4'b1000; rw = 4'b0000;
        tick();
        chk("err_read", 32'(read_fifo), 0);
        chk("err_valid", 32'(rsp_valid), 1);
        chk("err_flag", 32'(rsp_err), 1);
        chk("err_data", 32'(rsp_data), 0);
        chk("err_id", 32'(rsp_id), 3);
        repeat (3) tick();

        // all four hold pushes, mailbox drained: strict rotation and fixed spacing
        do_reset();
        hold_all = 1; drain_pct = 100; rv = 4'b1111; rw = 4'b1111;
        wait_grants(5, 40);
        if (grants.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", grants[k], k % NREQ);
            for (int k = 0; k < 4; k++) chk("rr_spacing", gcyc[k+1] - gcyc[k], 2 + GAP);
        end
        hold_all = 0;

        // reset in the strobe cycle of a push
        do_reset();
        rv = 4'b0100; rw = 4'b0100;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_write", 32'(write_fifo), 0);
        chk("rst_mid_level", 32'(level), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ready", 32'(req_ready), 0);
        do_reset();
        rv = 4'b1010; rw = 4'b1010;
        tick();
        chk("rst_ptr_restart", 32'(req_ready), 32'b0010);
        repeat (6) tick();

        // randomized traffic: push-heavy with slow drain, then pop-heavy with fast drain
        do_reset();
        rand_mode = 1; wr_pct = 75; drain_pct = 8;
        repeat (1500) tick();
        do_reset();
        rand_mode = 1; wr_pct = 40; drain_pct = 30;
        repeat (1500) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
